// File: rtl/mem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port memory controller.
// Each transaction runs IDLE -> ISSUE -> WAIT -> RESP. The command stays
// stable until the controller answers with ready. A watchdog ends a hung
// WAIT with an error acknowledge.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wdata,
    output logic                  p0_ack,
    output logic                  p0_err,
    output logic [DATA_WIDTH-1:0] p0_rdata,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wdata,
    output logic                  p1_ack,
    output logic                  p1_err,
    output logic [DATA_WIDTH-1:0] p1_rdata,
    output logic                  mc_wr_en,
    output logic                  mc_rd_en,
    output logic [ADDR_WIDTH-1:0] mc_addr,
    output logic [DATA_WIDTH-1:0] mc_wr_data,
    input  logic [DATA_WIDTH-1:0] mc_rd_data,
    input  logic                  mc_ready
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Last WAIT cycle index. When this is reached without ready, the
    // transaction is ended with an error.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t                r_state;
    logic                  r_last_grant;
    logic                  r_grant;
    logic                  r_we;
    logic [7:0]            r_cnt;
    logic                  r_mc_wr_en;
    logic                  r_mc_rd_en;
    logic [ADDR_WIDTH-1:0] r_mc_addr;
    logic [DATA_WIDTH-1:0] r_mc_wr_data;
    logic                  r_p0_ack;
    logic                  r_p0_err;
    logic [DATA_WIDTH-1:0] r_p0_rdata;
    logic                  r_p1_ack;
    logic                  r_p1_err;
    logic [DATA_WIDTH-1:0] r_p1_rdata;

    // Port selection: a lone requester wins; on contention the port that
    // did not win last time is chosen (0 = port 0, 1 = port 1).
    logic                  w_sel;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    assign w_sel   = (p0_req && p1_req) ? ~r_last_grant : p1_req;
    assign w_we    = w_sel ? p1_we    : p0_we;
    assign w_addr  = w_sel ? p1_addr  : p0_addr;
    assign w_wdata = w_sel ? p1_wdata : p0_wdata;

    // Transaction sequencer with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_we         <= 1'b0;
            r_cnt        <= 8'd0;
            r_mc_wr_en   <= 1'b0;
            r_mc_rd_en   <= 1'b0;
            r_mc_addr    <= '0;
            r_mc_wr_data <= '0;
            r_p0_ack     <= 1'b0;
            r_p0_err     <= 1'b0;
            r_p0_rdata   <= '0;
            r_p1_ack     <= 1'b0;
            r_p1_err     <= 1'b0;
            r_p1_rdata   <= '0;
        end else begin
            // Command enables and acknowledges are single-cycle pulses.
            r_mc_wr_en <= 1'b0;
            r_mc_rd_en <= 1'b0;
            r_p0_ack   <= 1'b0;
            r_p0_err   <= 1'b0;
            r_p1_ack   <= 1'b0;
            r_p1_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (p0_req || p1_req) begin
                        r_grant      <= w_sel;
                        r_last_grant <= w_sel;
                        r_we         <= w_we;
                        r_mc_addr    <= w_addr;
                        r_mc_wr_data <= w_wdata;
                        // Enable is visible during the ISSUE cycle only.
                        r_mc_wr_en   <= w_we;
                        r_mc_rd_en   <= ~w_we;
                        r_state      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_cnt   <= 8'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (mc_ready) begin
                        // Writes leave the port's read data untouched.
                        if (!r_we) begin
                            if (r_grant) r_p1_rdata <= mc_rd_data;
                            else         r_p0_rdata <= mc_rd_data;
                        end
                        if (r_grant) r_p1_ack <= 1'b1;
                        else         r_p0_ack <= 1'b1;
                        r_state <= S_RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        if (r_grant) begin
                            r_p1_ack <= 1'b1;
                            r_p1_err <= 1'b1;
                        end else begin
                            r_p0_ack <= 1'b1;
                            r_p0_err <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end
                end
                S_RESP: begin
                    // Requests are not sampled here. A request that is still
                    // high is picked up as a new one in IDLE.
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign mc_wr_en   = r_mc_wr_en;
    assign mc_rd_en   = r_mc_rd_en;
    assign mc_addr    = r_mc_addr;
    assign mc_wr_data = r_mc_wr_data;
    assign p0_ack     = r_p0_ack;
    assign p0_err     = r_p0_err;
    assign p0_rdata   = r_p0_rdata;
    assign p1_ack     = r_p1_ack;
    assign p1_err     = r_p1_err;
    assign p1_rdata   = r_p1_rdata;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester round-robin arbiter and sequencer in front of the single-port memory controller (wr_en/rd_en/addr/wr_data/rd_data/ready interface).
- Each requester gets a held request / one-cycle ack handshake.
- The arbiter issues one command at a time and holds address/data stable until the controller's ready pulse.
- A watchdog terminates a hung transaction with an error ack.

Parameters:
- ADDR_WIDTH, 8, address width (matches controller).
- DATA_WIDTH, 8, data width (matches controller).
- TIMEOUT, 15, max cycles in WAIT without mc_ready before error ack; range 1..255.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  asynchronous, active-high reset.
- p0_req / p1_req  in  1  request; held high with payload stable until ack.
- p0_we / p1_we  in  1  1 = write, 0 = read.
- p0_addr / p1_addr  in  ADDR_WIDTH  address.
- p0_wdata / p1_wdata  in  DATA_WIDTH  write data.
- p0_ack / p1_ack  out  1  one-cycle completion pulse.
- p0_err / p1_err  out  1  valid with ack; 1 = timeout.
- p0_rdata / p1_rdata  out  DATA_WIDTH  read data, valid with ack; held until next ack on that port.
- mc_wr_en  out  1  write command pulse to controller.
- mc_rd_en  out  1  read command pulse to controller.
- mc_addr  out  ADDR_WIDTH  address to controller.
- mc_wr_data  out  DATA_WIDTH  write data to controller.
- mc_rd_data  in  DATA_WIDTH  controller read data.
- mc_ready  in  1  controller completion pulse.

Behaviour:
- Reset: all outputs 0; state IDLE; last_grant = 1 (port 0 wins first contest); timeout counter 0.
- All outputs are registered.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If any req is high, select a port. A single requester wins. If both request, grant the port != last_grant.
  - Latch we/addr/wdata into mc_addr/mc_wr_data/internal we; record grant; update last_grant; go to ISSUE.
- ISSUE (1 cycle): mc_wr_en = we or mc_rd_en = !we asserted for exactly this cycle; go to WAIT; clear counter.
- WAIT:
  - mc_addr/mc_wr_data held; counter increments each cycle.
  - On mc_ready = 1: latch mc_rd_data (reads only) into granted port's rdata; set ack = 1, err = 0 for next cycle; go to RESP.
  - If counter reaches TIMEOUT with no mc_ready: rdata unchanged, ack = 1, err = 1; go to RESP.
- RESP (1 cycle): granted port's ack (and err if set) high; requests are not sampled; next IDLE.
- A requester whose req is still high in the cycle after ack has made a new request.
- Nominal latency with the controller: req sampled in cycle N -> mc_*_en in N+1 -> mc_ready in N+3 -> ack in N+4. A back-to-back request is accepted at N+5.
- mc_ready outside WAIT is ignored.
- A req that drops before grant is simply not served. A req that drops after grant does not cancel the transaction; its ack is still produced.
- A write never alters that port's rdata.
- Ungranted port's ack/err remain 0.
- mc_wr_en and mc_rd_en are never high together; never high outside ISSUE.
- Reset mid-transaction: immediate return to reset values. The in-flight transaction is dropped with no ack.

Test Plan:
- Single write: p0 req, we=1, addr=0x12, wdata=0xA5 -> mc_wr_en pulses one cycle with mc_addr=0x12, mc_wr_data=0xA5; p0_ack at req+4 cycles; err=0.
- Single read: memory model returns 0x3C at 0x40; p1 read addr=0x40 -> mc_rd_en one pulse; p1_ack with p1_rdata=0x3C; p0_ack stays 0.
- Contention: both req high from reset with continuous requests -> grants alternate p0, p1, p0, p1. Each ack is exactly one cycle; no overlap of mc commands.
- Timeout: controller model never asserts ready, TIMEOUT=15 -> ack with err=1 after 15 WAIT cycles; p0_rdata keeps its previous value; the next request is served normally.
- Back-to-back: p0 holds req through ack with new addr=0x01 then 0x02 -> two separate transactions; second command issued exactly 2 cycles after first ack.
- Reset mid-WAIT: assert rst in WAIT -> all outputs 0 same cycle, no ack. After release, a p1-only request is served, then a both-request contest goes to p0.
